// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial packed-BCD adder/subtractor, one digit per
// clock, least significant digit first, behind a start/done handshake.
// Subtraction is done as A + nines(B) + 1; a missing final carry means A<B,
// and a second digit-serial pass (FIX) turns the tens complement back into
// the magnitude so that result is always |A-B| with neg flagging the sign.
// Operand digits above 9 are rejected at capture and reported via invalid.
//
// Optional feature macro: BCD_SUB_EN
//   defined   : sub input honoured, FIX state built, neg functional
//   undefined : sub ignored (always add), no FIX state, neg tied to 0

module bcd_serial_addsub #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  invalid
);

  // Digit index width; a one-digit build still needs a one-bit index.
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

`ifdef BCD_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
`ifdef BCD_SUB_EN
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  // One decimal digit step: returns {carry, digit} with the +6 correction
  // applied whenever the binary sum leaves the 0..9 range.
  function automatic logic [4:0] dec_step(input logic [3:0] x,
                                          input logic [3:0] y,
                                          input logic       cin);
    logic [4:0] t;
    logic [4:0] tc;
    t  = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    tc = t + 5'd6;
    if (t > 5'd9) return {1'b1, tc[3:0]};
    else          return {1'b0, t[3:0]};
  endfunction

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                c_q, c_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic                sub_q, sub_d;
  logic [4*DIGITS-1:0] result_q, result_d;
  logic                cout_q, cout_d;
  logic                neg_q, neg_d;
  logic                invalid_q, invalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                bad_digit;
  logic                sub_eff;
  logic [3:0]          a_digit;
  logic [3:0]          b_digit;
  logic [3:0]          b_operand;
  logic [3:0]          res_digit;
  logic [4:0]          add_step;
  logic [4:0]          fix_step;

  // Flag any non-BCD digit in the live operand inputs so it can be caught at capture.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) bad_digit = 1'b1;
    end
  end

  // Per-digit datapath: select digit k of each operand and compute both the ADD and FIX steps.
  always_comb begin
    sub_eff   = sub_q & SUB_EN;
    a_digit   = a_q[4*k_q +: 4];
    b_digit   = b_q[4*k_q +: 4];
    res_digit = result_q[4*k_q +: 4];
    b_operand = sub_eff ? (4'd9 - b_digit) : b_digit;
    add_step  = dec_step(a_digit, b_operand, c_q);
    fix_step  = dec_step(4'd9 - res_digit, 4'd0, c_q);
  end

  // Next-state and next-output logic for the IDLE/ADD/FIX/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    result_d  = result_q;
    cout_d    = cout_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          sub_d     = sub & SUB_EN;
          result_d  = '0;
          cout_d    = 1'b0;
          neg_d     = 1'b0;
          invalid_d = 1'b0;
          k_d       = '0;
          busy_d    = 1'b1;
          if (bad_digit) begin
            invalid_d = 1'b1;
            state_d   = S_DONE;
            done_d    = 1'b1;
          end else begin
            c_d     = sub & SUB_EN;
            state_d = S_ADD;
          end
        end
      end

      S_ADD: begin
        result_d[4*k_q +: 4] = add_step[3:0];
        c_d = add_step[4];
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d = '0;
          if (!sub_eff) begin
            cout_d  = add_step[4];
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (add_step[4]) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
`ifdef BCD_SUB_EN
            neg_d   = 1'b1;
            c_d     = 1'b1;
            state_d = S_FIX;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef BCD_SUB_EN
      S_FIX: begin
        result_d[4*k_q +: 4] = fix_step[3:0];
        c_d = fix_step[4];
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        k_d     = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      c_q       <= c_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign neg     = neg_q & SUB_EN;
  assign invalid = invalid_q;

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised, digit-serial BCD adder/subtractor for packed BCD operands of `DIGITS` decimal digits. It is the sequential successor to the fixed three-digit ripple BCD adder in the arithmetic lab datapath. It processes one digit per clock, LSB digit first, behind a start/done handshake. It adds sign-magnitude subtraction and detection of invalid (non-BCD) digits.

## Interface
- `DIGITS`, default 3: number of BCD digits per operand; legal range 1..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request pulse or level; sampled only in IDLE.
- `sub` input 1: 0 = A+B, 1 = A−B; captured with operands.
- `a` input 4·DIGITS: operand A, packed BCD; digit i is bits [4i+3:4i].
- `b` input 4·DIGITS: operand B, packed BCD.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the result is valid.
- `result` output 4·DIGITS: packed BCD sum, or magnitude of the difference.
- `cout` output 1: decimal carry out of the top digit (add only; 0 for sub).
- `neg` output 1: subtract result is negative; `result` holds |A−B|.
- `invalid` output 1: some operand digit was >9 at capture.

## Operation
- States: IDLE, ADD, FIX, DONE.
- IDLE with `start`=1: capture `a`, `b` and `sub`, then clear `result`, `cout`, `neg` and `invalid`.
  - If any captured digit of A or B is >9: set `invalid`=1 and go to DONE. `result`=0, `cout`=0, `neg`=0.
  - Otherwise: digit index k=0, carry c = `sub` (1 for subtract), go to ADD.
- ADD, one digit per cycle:
  - b' = B[k] for add, 9−B[k] for subtract (nines complement).
  - t = A[k] + b' + c, 5-bit.
  - If t>9: digit = (t+6)[3:0] and c=1. Otherwise digit = t[3:0] and c=0.
  - Write the digit to `result[k]`, then k++. After k = DIGITS−1 the final c is resolved:
  - Add: `cout`=c, go to DONE.
  - Subtract with c=1: A≥B, `neg`=0, go to DONE.
  - Subtract with c=0: A<B. `result` holds the tens complement, so set `neg`=1, k=0, c=1 and go to FIX.
- FIX, one digit per cycle: t = (9−result[k]) + c, with the same decimal correction as ADD. Write back to `result[k]`, then k++. After DIGITS−1 go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`=1; no queuing.
- Outputs hold their values from DONE until the next accepted start.
- A−B with A=B gives `result`=0 and `neg`=0; zero is never negative.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, k=0, `busy`=0, `done`=0, `result`=0, `cout`=0, `neg`=0, `invalid`=0.
- Reset mid-operation aborts immediately to these values. The first start after release is accepted normally.
- Edge E0 samples `start`. Clock edges, counted from E0, until `done` is high:
  - Add, or subtract with A≥B: DIGITS+1 edges.
  - Subtract with A<B: 2·DIGITS+1 edges.
  - Invalid input: 1 edge.
- `busy` rises at E0 and falls on the edge that ends the DONE cycle.
- A new start is accepted in the cycle immediately after DONE.
- `result` digits update one per cycle during ADD and FIX. They are only architecturally valid while `done`=1 or afterwards.

## Configuration
- `BCD_SUB_EN` defined: subtract path, FIX state and `neg` are fully functional.
- `BCD_SUB_EN` undefined:
  - `sub` is ignored and treated as 0; the FIX state is not built.
  - `neg` is tied to 0.
  - Latency is always DIGITS+1 edges (1 edge for invalid input).

## Test plan
- DIGITS=3, add 0x999 + 0x001 → `result`=0x000, `cout`=1, `done` 4 edges after start.
- Add 0x123 + 0x456 → `result`=0x579, `cout`=0, `neg`=0, `invalid`=0.
- Sub 0x500 − 0x123 → `result`=0x377, `neg`=0, latency 4. Sub 0x123 − 0x500 → `result`=0x377, `neg`=1, latency 7.
- Add with `a`=0x1A3 → `invalid`=1, `result`=0x000, `done` 1 edge after start.
- Assert `start` with new operands while `busy` → ignored, first result unchanged. Then drop `rst_n` mid-ADD → all outputs 0 at once, `busy`=0.
- DIGITS=8, sub 0x00000000 − 0x00000001 → `result`=0x00000001, `neg`=1, latency 17. Build without `BCD_SUB_EN`: the same stimulus gives the add result 0x00000001 with latency 9.
